// File: rtl/toaplan2_eeprom_pkg.sv
// Shared opcodes, FSM encoding and constants for the 93C46 x16 serial EEPROM model.
package toaplan2_eeprom_pkg;
  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  localparam logic [1:0] SUB_EWDS = 2'b00;
  localparam logic [1:0] SUB_WRAL = 2'b01;
  localparam logic [1:0] SUB_ERAL = 2'b10;
  localparam logic [1:0] SUB_EWEN = 2'b11;

  localparam logic [15:0] ERASED_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_CMD, ST_READ_OUT, ST_WRITE_IN, ST_WAIT_CS, ST_BUSY
  } state_e;

  typedef enum logic [2:0] {
    P_NONE, P_WRITE, P_ERASE, P_ERAL, P_WRAL
  } pend_e;
endpackage

// File: rtl/toaplan2_eeprom_sync.sv
// Synchronises SCLK/SCS/SDI into CLK and flags SCLK rising / SCS falling edges.
module toaplan2_eeprom_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic sclk_i,
  input  logic cs_i,
  input  logic sdi_i,
  output logic cs_o,
  output logic sdi_o,
  output logic sclk_rise_o,
  output logic cs_fall_o
);
  // One extra stage on SCLK/SCS holds the previous synchronised level.
  logic [STAGES:0]   sclk_q, cs_q;
  logic [STAGES-1:0] sdi_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sclk_q <= '0;
      cs_q   <= '0;
      sdi_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[STAGES-1:0], sclk_i};
      cs_q   <= {cs_q[STAGES-1:0], cs_i};
      sdi_q  <= {sdi_q[STAGES-2:0], sdi_i};
    end
  end

  assign cs_o        = cs_q[STAGES-1];
  assign sdi_o       = sdi_q[STAGES-1];
  assign sclk_rise_o = sclk_q[STAGES-1] & ~sclk_q[STAGES];
  assign cs_fall_o   = ~cs_q[STAGES-1] & cs_q[STAGES];
endmodule

// File: rtl/toaplan2_eeprom_93c46.sv
// 93C46 x16 serial EEPROM, oversampled by CLK. Define TOAPLAN2_EEPROM_DUMP_EN for a
// host save/load port (DUMP_*) and a DIRTY flag.
module toaplan2_eeprom_93c46
  import toaplan2_eeprom_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int BUSY_CYCLES = 4800,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic EEPROM_SCLK,
  input  logic EEPROM_SCS,
  input  logic EEPROM_SDI,
  output logic EEPROM_SDO,
  output logic WR_EN_STATE
`ifdef TOAPLAN2_EEPROM_DUMP_EN
  ,
  input  logic [ADDR_W-1:0] DUMP_ADDR,
  input  logic [DATA_W-1:0] DUMP_DIN,
  input  logic              DUMP_WE,
  output logic [DATA_W-1:0] DUMP_DOUT,
  output logic              DIRTY
`endif
);
  localparam int BW    = $clog2(BUSY_CYCLES);
  localparam int CW    = $clog2(DATA_W);
  localparam int WORDS = 2**ADDR_W;

  logic cs, sdi, sclk_rise, cs_fall;

  toaplan2_eeprom_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK(CLK), .RESET_N(RESET_N),
    .sclk_i(EEPROM_SCLK), .cs_i(EEPROM_SCS), .sdi_i(EEPROM_SDI),
    .cs_o(cs), .sdi_o(sdi), .sclk_rise_o(sclk_rise), .cs_fall_o(cs_fall)
  );

  // Words are stored inverted so the all-zero power-up state reads as erased.
  logic [DATA_W-1:0] mem_n [WORDS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, rd_word;

  state_e            state_q, state_d;
  pend_e             pend_q, pend_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CW-1:0]     bit_q, bit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     busy_q, busy_d;
  logic              sdo_q, sdo_d, wren_q, wren_d, fill_q, fill_d;
  logic [ADDR_W+1:0] cmd;

  assign cmd     = {sr_q[ADDR_W:0], sdi};
  assign rd_word = ~mem_n[addr_q];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      pend_q  <= P_NONE;
      sr_q    <= '0;
      bit_q   <= '0;
      addr_q  <= '0;
      busy_q  <= '0;
      sdo_q   <= 1'b1;
      wren_q  <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      sdo_q   <= sdo_d;
      wren_q  <= wren_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q; pend_d = pend_q; sr_d = sr_q; bit_d = bit_q;
    addr_d = addr_q; busy_d = busy_q; sdo_d = sdo_q; wren_d = wren_q; fill_d = fill_q;
    mem_we = 1'b0; mem_waddr = addr_q; mem_wdata = sr_q;
    if (cs_fall && (state_q inside {ST_START, ST_CMD, ST_READ_OUT, ST_WRITE_IN})) begin
      state_d = ST_IDLE;
      sdo_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (cs) state_d = ST_START;
        ST_START: if (sclk_rise && sdi) begin
          state_d = ST_CMD;
          bit_d   = '0;
        end
        ST_CMD: if (sclk_rise) begin
          sr_d  = {sr_q[DATA_W-2:0], sdi};
          bit_d = bit_q + 1'b1;
          if (bit_q == CW'(ADDR_W+1)) begin
            addr_d = cmd[ADDR_W-1:0];
            bit_d  = '0;
            pend_d = P_NONE;
            state_d = ST_WAIT_CS;
            case (cmd[ADDR_W+1:ADDR_W])
              OP_READ:  begin state_d = ST_READ_OUT; sdo_d = 1'b0; end
              OP_WRITE: begin state_d = ST_WRITE_IN; pend_d = P_WRITE; end
              OP_ERASE: pend_d = P_ERASE;
              default: case (cmd[ADDR_W-1:ADDR_W-2])
                SUB_EWEN: wren_d = 1'b1;
                SUB_EWDS: wren_d = 1'b0;
                SUB_ERAL: pend_d = P_ERAL;
                default:  begin state_d = ST_WRITE_IN; pend_d = P_WRAL; end
              endcase
            endcase
          end
        end
        ST_READ_OUT: if (sclk_rise) begin
          sdo_d = rd_word[CW'(DATA_W-1) - bit_q];
          bit_d = bit_q + 1'b1;
          if (bit_q == CW'(DATA_W-1)) begin
            bit_d  = '0;
            addr_d = addr_q + 1'b1;
          end
        end
        ST_WRITE_IN: if (sclk_rise) begin
          sr_d  = {sr_q[DATA_W-2:0], sdi};
          bit_d = bit_q + 1'b1;
          if (bit_q == CW'(DATA_W-1)) state_d = ST_WAIT_CS;
        end
        ST_WAIT_CS: if (cs_fall) begin
          if (!wren_q || pend_q == P_NONE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BUSY;
            busy_d  = '0;
            case (pend_q)
              P_WRITE: mem_we = 1'b1;
              P_ERASE: begin mem_we = 1'b1; mem_wdata = DATA_W'(ERASED_WORD); end
              P_ERAL:  begin fill_d = 1'b1; sr_d = DATA_W'(ERASED_WORD); end
              default: fill_d = 1'b1;
            endcase
          end
        end
        ST_BUSY: begin
          // Bulk ops sweep the array one word per CLK at the start of the busy window.
          if (fill_q && busy_q < BW'(WORDS)) begin
            mem_we    = 1'b1;
            mem_waddr = busy_q[ADDR_W-1:0];
          end
          if (busy_q == BW'(BUSY_CYCLES-1)) begin
            state_d = ST_IDLE;
            sdo_d   = 1'b1;
            fill_d  = 1'b0;
          end else begin
            busy_d = busy_q + 1'b1;
            sdo_d  = ~cs;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef TOAPLAN2_EEPROM_DUMP_EN
  logic [DATA_W-1:0] dump_q;
  logic              dirty_q;

  always_ff @(posedge CLK) begin
    if (mem_we) mem_n[mem_waddr] <= ~mem_wdata;
    if (DUMP_WE) mem_n[DUMP_ADDR] <= ~DUMP_DIN;
    dump_q <= ~mem_n[DUMP_ADDR];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     dirty_q <= 1'b0;
    else if (mem_we)  dirty_q <= 1'b1;
    else if (DUMP_WE) dirty_q <= 1'b0;
  end

  assign DUMP_DOUT = dump_q;
  assign DIRTY     = dirty_q;
`else
  always_ff @(posedge CLK) begin
    if (mem_we) mem_n[mem_waddr] <= ~mem_wdata;
  end
`endif

  assign EEPROM_SDO  = sdo_q;
  assign WR_EN_STATE = wren_q;
endmodule

// File: tb/tb_toaplan2_eeprom_93c46.sv
// Randomised bench for the 93C46 model: a word-array reference drives expected SDO bits.
module tb_toaplan2_eeprom_93c46;
  localparam int BC = 4800;

  logic CLK = 1'b0, RESET_N = 1'b0, SCLK = 1'b0, SCS = 1'b0, SDI = 1'b0;
  logic SDO, WREN;

  toaplan2_eeprom_93c46 dut (
    .CLK(CLK), .RESET_N(RESET_N), .EEPROM_SCLK(SCLK), .EEPROM_SCS(SCS),
    .EEPROM_SDI(SDI), .EEPROM_SDO(SDO), .WR_EN_STATE(WREN)
  );

  always #10 CLK = ~CLK;

  logic [15:0] mem_m [64];
  bit   wren_m = 1'b0, wren_chk = 1'b0, exp_valid = 1'b0, exp_sdo = 1'b1;
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Every cycle: streamed SDO against the model's current expectation, plus the enable latch.
  always @(negedge CLK) if (RESET_N) begin
    if (exp_valid) chk("sdo_stream", 32'(SDO), 32'(exp_sdo));
    if (wren_chk)  chk("wr_en_state", 32'(WREN), 32'(wren_m));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic sbit(input bit b, input bit c, input bit e, output bit obs);
    SCLK = 1'b0; SDI = b; cycles(5);
    exp_valid = 1'b0; SCLK = 1'b1; cycles(5);
    obs = SDO; exp_sdo = e; exp_valid = c;
  endtask

  task automatic cs_up();
    SCS = 1'b1; cycles(4);
  endtask

  task automatic cs_down();
    exp_valid = 1'b0; SCS = 1'b0; SCLK = 1'b0; cycles(5);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] a, input bit rd);
    bit o;
    int lead = $urandom_range(0, 2);
    for (int i = 0; i < lead; i++) sbit(1'b0, 1'b1, 1'b1, o);
    sbit(1'b1, 1'b1, 1'b1, o);
    for (int i = 1; i >= 0; i--) sbit(op[i], 1'b1, 1'b1, o);
    for (int i = 5; i >= 0; i--) sbit(a[i], 1'b1, (i == 0) ? !rd : 1'b1, o);
  endtask

  // Drop CS, re-raise it to poll ready/busy, then deselect.
  task automatic finish_op(input bit busy);
    int cnt;
    exp_valid = 1'b0; SCS = 1'b0; SCLK = 1'b0; cycles(8);
    SCS = 1'b1; cycles(6); cnt = 14;
    if (busy) begin
      chk("busy_low", 32'(SDO), 32'd0);
      while (SDO !== 1'b1 && cnt < 3*BC) begin @(negedge CLK); cnt++; end
      checks++;
      if (cnt < BC || cnt > BC + 8) begin
        failures++;
        $display("FAIL busy_len actual=%0d required=%0d..%0d", cnt, BC, BC + 8);
      end
    end else begin
      cycles(30);
      chk("no_busy_ready", 32'(SDO), 32'd1);
    end
    SCS = 1'b0; cycles(5);
  endtask

  task automatic do_read(input int a0, input int n, output logic [15:0] first, output logic [15:0] last);
    bit o;
    logic [15:0] w = '0;
    int a = a0;
    first = '0; last = '0;
    cs_up();
    send_cmd(2'b10, 6'(a), 1'b1);
    for (int k = 0; k < n; k++) begin
      for (int i = 15; i >= 0; i--) begin
        sbit(1'($urandom_range(0, 1)), 1'b1, mem_m[a][i], o);
        w[i] = o;
      end
      if (k == 0) first = w;
      last = w;
      a = (a + 1) % 64;
    end
    cs_down();
    chk("idle_sdo", 32'(SDO), 32'd1);
  endtask

  task automatic do_write(input int a, input logic [15:0] d, input int nbits);
    bit o;
    cs_up();
    send_cmd(2'b01, 6'(a), 1'b0);
    for (int i = 15; i >= 16 - nbits; i--) sbit(d[i], 1'b1, 1'b1, o);
    if (nbits == 16) begin
      finish_op(wren_m);
      if (wren_m) mem_m[a] = d;
    end else begin
      cs_down(); cycles(20);
      chk("abort_sdo", 32'(SDO), 32'd1);
    end
  endtask

  task automatic do_erase(input int a);
    cs_up();
    send_cmd(2'b11, 6'(a), 1'b0);
    finish_op(wren_m);
    if (wren_m) mem_m[a] = 16'hFFFF;
  endtask

  task automatic do_ew(input bit en);
    wren_chk = 1'b0;
    cs_up();
    send_cmd(2'b00, {en, en, 4'($urandom_range(0, 15))}, 1'b0);
    cycles(2);
    chk(en ? "ewen_latch" : "ewds_latch", 32'(WREN), 32'(en));
    wren_m = en; wren_chk = 1'b1;
    finish_op(1'b0);
  endtask

  task automatic do_bulk(input bit wral, input logic [15:0] d);
    bit o;
    cs_up();
    send_cmd(2'b00, {~wral, wral, 4'($urandom_range(0, 15))}, 1'b0);
    if (wral) for (int i = 15; i >= 0; i--) sbit(d[i], 1'b1, 1'b1, o);
    finish_op(wren_m);
    if (wren_m) for (int i = 0; i < 64; i++) mem_m[i] = wral ? d : 16'hFFFF;
  endtask

  initial begin
    logic [15:0] f, l, d;
    bit o;
    int a;
    for (int i = 0; i < 64; i++) mem_m[i] = 16'hFFFF;
    cycles(3);
    chk("reset_sdo", 32'(SDO), 32'd1);
    chk("reset_wren", 32'(WREN), 32'd0);
    RESET_N = 1'b1; cycles(3); wren_chk = 1'b1;

    do_read(5, 1, f, l);           chk("read_erased", 32'(f), 32'h0000FFFF);
    do_ew(1'b1);
    do_write(5, 16'hA55A, 16);
    do_read(5, 1, f, l);           chk("read_a55a", 32'(f), 32'h0000A55A);
    do_ew(1'b0);
    do_write(5, 16'h1234, 16);
    do_read(5, 1, f, l);           chk("ewds_protect", 32'(f), 32'h0000A55A);

    do_ew(1'b1);
    do_write(63, 16'hC3E1, 16);
    do_write(0, 16'h5A0F, 16);
    do_read(63, 2, f, l);
    chk("wrap_word63", 32'(f), 32'h0000C3E1);
    chk("wrap_word0",  32'(l), 32'h00005A0F);

    do_bulk(1'b0, 16'h0000);
    do_read(0, 64, f, l);          chk("eral_last", 32'(l), 32'h0000FFFF);
    do_bulk(1'b1, 16'h0F0F);
    do_read(0, 64, f, l);          chk("wral_last", 32'(l), 32'h00000F0F);

    do_write(5, 16'h1234, 10);
    do_read(5, 1, f, l);           chk("abort_nochange", 32'(f), 32'h00000F0F);

    for (int n = 0; n < 10; n++) begin
      int r = $urandom_range(0, 9);
      a = $urandom_range(0, 63);
      d = 16'($urandom);
      case (r)
        0, 1, 2: do_write(a, d, 16);
        3:       do_erase(a);
        4, 5, 6: do_read(a, $urandom_range(1, 3), f, l);
        7:       do_ew(1'b1);
        8:       do_ew(1'b0);
        default: do_write(a, d, $urandom_range(1, 15));
      endcase
    end

    if (!wren_m) do_ew(1'b1);
    a = $urandom_range(0, 63);
    cs_up();
    send_cmd(2'b10, 6'(a), 1'b1);
    for (int i = 15; i >= 9; i--) sbit(1'b0, 1'b1, mem_m[a][i], o);
    exp_valid = 1'b0; wren_chk = 1'b0;
    #3 RESET_N = 1'b0;
    #1;
    chk("midread_reset_sdo",  32'(SDO),  32'd1);
    chk("midread_reset_wren", 32'(WREN), 32'd0);
    wren_m = 1'b0; SCS = 1'b0; SCLK = 1'b0;
    cycles(3); RESET_N = 1'b1; cycles(3); wren_chk = 1'b1;
    do_read(a, 1, f, l);           chk("array_kept", 32'(f), 32'(mem_m[a]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #4_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
